// File: rtl/div_pkg.sv
// Shared definitions for the sequential integer divider: data width,
// RV32M divide op encoding, FSM states and the forced special-case result.
package div_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   // Bit 1 selects remainder, bit 0 selects unsigned.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_e;

   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input div_op_e op);
      return ~op[0];
   endfunction

   // Result for divide-by-zero (div_zero = 1) or signed overflow (div_zero = 0).
   function automatic logic [XLEN-1:0] forced_result(input div_op_e         op,
                                                     input logic [XLEN-1:0] dividend,
                                                     input logic            div_zero);
      if (div_zero) begin
         return op_is_rem(op) ? dividend : {XLEN{1'b1}};
      end
      return op_is_rem(op) ? {XLEN{1'b0}} : INT_MIN;
   endfunction

endpackage

// File: rtl/integer_division_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The {remainder, quotient} pair is shifted left by one; the divisor is
// trial-subtracted from the 33-bit partial remainder and, when the result
// is non-negative, it is kept and the new quotient LSB is set.
module integer_division_step
   import div_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] partial;
   logic          nonneg;

   // Shift, trial-subtract, restore or keep.
   always_comb begin
      partial = {rem_i, quo_i[XLEN-1]};
      nonneg  = (partial >= {1'b0, divisor_i});
      // A kept difference is always below the divisor, so 32 bits hold it exactly.
      rem_o   = nonneg ? (partial[XLEN-1:0] - divisor_i) : partial[XLEN-1:0];
      quo_o   = {quo_i[XLEN-2:0], nonneg};
   end

endmodule

// File: rtl/integer_division_unit.sv
// Sequential 32-bit RV32M divider (DIV, DIVU, REM, REMU), one quotient bit
// per clock, with a start/busy/done handshake.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow finish at the accepting edge instead of running 33 cycles.
module integer_division_unit
   import div_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] operand1_i,
   input  logic [XLEN-1:0] operand2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   div_state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;       // all 32 iterations have been applied
   div_op_e          op_q, op_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div_zero_q, div_zero_d;
   logic             ovf_q, ovf_d;
   logic [XLEN-1:0]  dividend_q, dividend_d; // original dividend, for rem-by-zero
   logic [XLEN-1:0]  divisor_q, divisor_d;   // |divisor| for signed ops
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  result_q, result_d;

   div_op_e         op_in;
   logic            in_signed;
   logic            in_div_zero;
   logic            in_ovf;
   logic [XLEN-1:0] op1_abs;
   logic [XLEN-1:0] op2_abs;
   logic [XLEN-1:0] step_rem;
   logic [XLEN-1:0] step_quo;

   assign op_in       = div_op_e'(op_i);
   assign in_signed   = op_is_signed(op_in);
   assign in_div_zero = (operand2_i == '0);
   assign in_ovf      = in_signed && (operand1_i == INT_MIN) && (operand2_i == '1);
   // Negating INT_MIN wraps back to 0x80000000, which is the wanted unsigned magnitude.
   assign op1_abs     = (in_signed && operand1_i[XLEN-1]) ? -operand1_i : operand1_i;
   assign op2_abs     = (in_signed && operand2_i[XLEN-1]) ? -operand2_i : operand2_i;

   integer_division_step u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value, independent of statement order.
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and datapath next values.
   always_comb begin
      // NOTE: every _d starts as its _q (or a fixed state), so no path through
      // the case leaves a signal unassigned and no latch is inferred.
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      op_d       = op_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      ovf_d      = ovf_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      result_d   = result_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d    = RUN;
               cnt_d      = '0;
               last_d     = 1'b0;
               op_d       = op_in;
               neg_quo_d  = in_signed && (operand1_i[XLEN-1] ^ operand2_i[XLEN-1]);
               neg_rem_d  = in_signed && operand1_i[XLEN-1];
               div_zero_d = in_div_zero;
               ovf_d      = in_ovf;
               dividend_d = operand1_i;
               divisor_d  = op2_abs;
               rem_d      = '0;
               quo_d      = op1_abs;
`ifdef DIV_FAST_SPECIAL_EN
               if (in_div_zero || in_ovf) begin
                  state_d  = DONE;
                  result_d = forced_result(op_in, operand1_i, in_div_zero);
               end
`endif
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            if (!last_q) begin
               rem_d  = step_rem;
               quo_d  = step_quo;
               cnt_d  = cnt_q + 1'b1;
               last_d = (cnt_q == '1);
            end else begin
               state_d = DONE;
               if (div_zero_q || ovf_q) begin
                  result_d = forced_result(op_q, dividend_q, div_zero_q);
               end else if (op_is_rem(op_q)) begin
                  result_d = neg_rem_q ? -rem_q : rem_q;
               end else begin
                  result_d = neg_quo_q ? -quo_q : quo_q;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Datapath registers; all cleared on reset so an aborted run leaves nothing behind.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         last_q     <= 1'b0;
         op_q       <= DIV;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         result_q   <= '0;
      end else begin
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         op_q       <= op_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
         ovf_q      <= ovf_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         result_q   <= result_d;
      end
   end

   assign busy_o   = (state_q == RUN);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_integer_division_unit.sv
// Directed bench for integer_division_unit. Latency expectations for the
// divide-by-zero / overflow cases follow DIV_FAST_SPECIAL_EN.
module tb_integer_division_unit;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   // Edge offset (after the accepting edge) at which done_o is seen high.
   localparam int NORMAL_LAT  = 33;
`ifdef DIV_FAST_SPECIAL_EN
   localparam int SPECIAL_LAT = 0;
`else
   localparam int SPECIAL_LAT = 33;
`endif

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          lat;
   logic [31:0] res;
   logic        bok;

   integer_division_unit dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .op_i       (op),
      .operand1_i (a),
      .operand2_i (b),
      .busy_o     (busy),
      .done_o     (done),
      .result_o   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present one request for exactly one accepting edge; returns #1 after it.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Wait for done_o, starting 'already' edges after the accepting edge.
   // busy_ok = busy high on every cycle before done and low in the done cycle.
   task automatic wait_done(input int already, output int l, output logic [31:0] r,
                            output logic busy_ok);
      l = -1; r = 'x; busy_ok = 1'b1;
      if (done) begin
         l = already; r = result;
         if (busy) busy_ok = 1'b0;
      end else begin
         for (int n = already + 1; n <= already + 100; n++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (done) begin
               l = n; r = result;
               if (busy) busy_ok = 1'b0;
               break;
            end
         end
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      start_op(o, x, y);
      wait_done(0, lat, res, bok);
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; op = OP_DIV; a = '0; b = '0;
      repeat (2) @(posedge clk); #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: busy %b done %b expected 0 0", busy, done); else pass_cnt++;
   endtask

   task automatic test_div_basic;
      run_op(OP_DIV, 32'd100, 32'd7);
      total_cnt++; if (res !== 32'd14) $display("FAIL div_100_7: got %h expected 0000000e", res); else pass_cnt++;
      total_cnt++; if (lat !== NORMAL_LAT) $display("FAIL div_100_7_latency: got %0d expected %0d", lat, NORMAL_LAT); else pass_cnt++;
      total_cnt++; if (bok !== 1'b1) $display("FAIL div_100_7_busy: got %b expected 1", bok); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL done_single_pulse: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (result !== 32'd14) $display("FAIL result_held_idle: got %h expected 0000000e", result); else pass_cnt++;
   endtask

   task automatic test_signed;
      run_op(OP_REM, 32'hFFFF_FFF9, 32'd3);
      total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL rem_m7_3: got %h expected ffffffff", res); else pass_cnt++;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd3);
      total_cnt++; if (res !== 32'hFFFF_FFFE) $display("FAIL div_m7_3: got %h expected fffffffe", res); else pass_cnt++;
      run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      total_cnt++; if (res !== 32'hFFFF_FFFD) $display("FAIL div_7_m2: got %h expected fffffffd", res); else pass_cnt++;
      run_op(OP_REM, 32'd7, 32'hFFFF_FFFE);
      total_cnt++; if (res !== 32'd1) $display("FAIL rem_7_m2: got %h expected 00000001", res); else pass_cnt++;
   endtask

   task automatic test_div_zero;
      run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0);
      total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL div_by_zero: got %h expected ffffffff", res); else pass_cnt++;
      total_cnt++; if (lat !== SPECIAL_LAT) $display("FAIL div_by_zero_latency: got %0d expected %0d", lat, SPECIAL_LAT); else pass_cnt++;
      total_cnt++; if (bok !== 1'b1) $display("FAIL div_by_zero_busy: got %b expected 1", bok); else pass_cnt++;
      run_op(OP_REM, 32'hFFFF_FFFB, 32'd0);
      total_cnt++; if (res !== 32'hFFFF_FFFB) $display("FAIL rem_by_zero: got %h expected fffffffb", res); else pass_cnt++;
      total_cnt++; if (lat !== SPECIAL_LAT) $display("FAIL rem_by_zero_latency: got %0d expected %0d", lat, SPECIAL_LAT); else pass_cnt++;
      run_op(OP_DIVU, 32'h1234_5678, 32'd0);
      total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu_by_zero: got %h expected ffffffff", res); else pass_cnt++;
      run_op(OP_REMU, 32'h1234_5678, 32'd0);
      total_cnt++; if (res !== 32'h1234_5678) $display("FAIL remu_by_zero: got %h expected 12345678", res); else pass_cnt++;
   endtask

   task automatic test_overflow;
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      total_cnt++; if (res !== 32'h8000_0000) $display("FAIL div_overflow: got %h expected 80000000", res); else pass_cnt++;
      total_cnt++; if (lat !== SPECIAL_LAT) $display("FAIL div_overflow_latency: got %0d expected %0d", lat, SPECIAL_LAT); else pass_cnt++;
      run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      total_cnt++; if (res !== 32'h0) $display("FAIL rem_overflow: got %h expected 00000000", res); else pass_cnt++;
      // Same bit patterns are ordinary for unsigned ops.
      run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      total_cnt++; if (res !== 32'h0) $display("FAIL divu_min_max: got %h expected 00000000", res); else pass_cnt++;
      total_cnt++; if (lat !== NORMAL_LAT) $display("FAIL divu_min_max_latency: got %0d expected %0d", lat, NORMAL_LAT); else pass_cnt++;
      run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF);
      total_cnt++; if (res !== 32'h8000_0000) $display("FAIL remu_min_max: got %h expected 80000000", res); else pass_cnt++;
      run_op(OP_DIV, 32'h8000_0000, 32'd1);
      total_cnt++; if (res !== 32'h8000_0000) $display("FAIL div_min_1: got %h expected 80000000", res); else pass_cnt++;
   endtask

   task automatic test_start_ignored;
      start_op(OP_DIV, 32'd100, 32'd7);
      @(negedge clk);
      start = 1'b1; op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'd2;
      repeat (3) @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, lat, res, bok);
      total_cnt++; if (res !== 32'd14) $display("FAIL start_in_run_result: got %h expected 0000000e", res); else pass_cnt++;
      total_cnt++; if (lat !== NORMAL_LAT) $display("FAIL start_in_run_latency: got %0d expected %0d", lat, NORMAL_LAT); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL start_in_run_no_restart: got %b expected 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run;
      logic saw_done;
      start_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
      repeat (10) @(posedge clk);
      #2; rst = 1'b1;
      #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else pass_cnt++;
      total_cnt++; if (result !== 32'h0) $display("FAIL abort_result: got %h expected 00000000", result); else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      saw_done = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      total_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: activity seen %b expected 0", saw_done); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
      total_cnt++; if (res !== 32'h7FFF_FFFF) $display("FAIL divu_max_2: got %h expected 7fffffff", res); else pass_cnt++;
      // Still in the DONE cycle: request the next op here.
      start = 1'b1; op = OP_REMU; a = 32'hFFFF_FFFF; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accepted: got %b expected 1", busy); else pass_cnt++;
      wait_done(0, lat, res, bok);
      total_cnt++; if (res !== 32'd1) $display("FAIL remu_max_2: got %h expected 00000001", res); else pass_cnt++;
      total_cnt++; if (lat !== NORMAL_LAT) $display("FAIL b2b_latency: got %0d expected %0d", lat, NORMAL_LAT); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_div_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
